// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings, owner
// codes and the watchdog counter width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Wide enough for the largest supported TIMEOUT (65535).
  localparam int CNT_W = 16;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and load/store ports.
// MEM_ARB_RR_EN defined   : round-robin on ties (the port not granted last wins).
// MEM_ARB_RR_EN undefined : fixed priority, load/store always wins ties.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
  input  owner_t last_owner,
  output logic   pick_if,
  output logic   pick_ls
);

`ifdef MEM_ARB_RR_EN
  // On a tie, hand the memory to whichever port did not own it last.
  always_comb begin
    pick_ls = ls_req && (!if_req || (last_owner == OWN_IF));
    pick_if = if_req && !pick_ls;
  end
`else
  // The last owner only matters for round-robin.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  // Load/store stalls the pipe, so it always beats fetch.
  always_comb begin
    pick_ls = ls_req;
    pick_if = if_req && !ls_req;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Request/grant/valid protocol, variable memory latency, wait-state watchdog.
// Arbitration policy selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_valid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_be,
  output logic            ls_gnt,
  output logic            ls_valid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata,
  output logic            err,
  output logic            busy
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_reg;
  owner_t           owner_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             acc_we_reg;
  logic [AW-1:0]    acc_addr_reg;
  logic [DW-1:0]    acc_wdata_reg;
  logic [DW/8-1:0]  acc_be_reg;
  logic             if_valid_reg;
  logic             ls_valid_reg;
  logic             err_reg;
  logic [DW-1:0]    if_rdata_reg;
  logic [DW-1:0]    ls_rdata_reg;
  logic             pick_if;
  logic             pick_ls;
  logic             idle;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .ls_req     (ls_req),
    .last_owner (owner_reg),
    .pick_if    (pick_if),
    .pick_ls    (pick_ls)
  );

  // Grants are only given while idle and never while reset is held.
  assign idle   = (state_reg == ARB_IDLE);
  assign if_gnt = rst && idle && pick_if;
  assign ls_gnt = rst && idle && pick_ls;

  // The memory side is driven purely from the access registers.
  assign busy      = !idle;
  assign mem_req   = !idle;
  assign mem_we    = acc_we_reg;
  assign mem_addr  = acc_addr_reg;
  assign mem_wdata = acc_wdata_reg;
  assign mem_be    = acc_be_reg;

  assign if_valid = if_valid_reg;
  assign ls_valid = ls_valid_reg;
  assign err      = err_reg;
  assign if_rdata = if_rdata_reg;
  assign ls_rdata = ls_rdata_reg;

  // Arbiter FSM: grant/capture in IDLE, wait for mem_ready or the watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ARB_IDLE;
      owner_reg     <= OWN_IF;
      wait_cnt_reg  <= '0;
      acc_we_reg    <= 1'b0;
      acc_addr_reg  <= '0;
      acc_wdata_reg <= '0;
      acc_be_reg    <= '0;
      if_valid_reg  <= 1'b0;
      ls_valid_reg  <= 1'b0;
      err_reg       <= 1'b0;
      if_rdata_reg  <= '0;
      ls_rdata_reg  <= '0;
    end else begin
      if_valid_reg <= 1'b0;
      ls_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          if (pick_ls) begin
            state_reg     <= ARB_DATA;
            owner_reg     <= OWN_LS;
            wait_cnt_reg  <= '0;
            acc_we_reg    <= ls_we;
            acc_addr_reg  <= ls_addr;
            acc_wdata_reg <= ls_we ? ls_wdata : '0;
            acc_be_reg    <= ls_we ? ls_be : '1;
          end else if (pick_if) begin
            state_reg     <= ARB_FETCH;
            owner_reg     <= OWN_IF;
            wait_cnt_reg  <= '0;
            acc_we_reg    <= 1'b0;
            acc_addr_reg  <= if_addr;
            acc_wdata_reg <= '0;
            acc_be_reg    <= '1;
          end
        end
        ARB_FETCH, ARB_DATA: begin
          if (mem_ready) begin
            state_reg <= ARB_IDLE;
            if (owner_reg == OWN_LS) begin
              ls_valid_reg <= 1'b1;
              ls_rdata_reg <= acc_we_reg ? '0 : mem_rdata;
            end else begin
              if_valid_reg <= 1'b1;
              if_rdata_reg <= mem_rdata;
            end
          end else if (wait_cnt_reg == LAST_WAIT) begin
            // Watchdog expired: this was the TIMEOUT-th wait cycle.
            state_reg <= ARB_IDLE;
            err_reg   <= 1'b1;
            if (owner_reg == OWN_LS) begin
              ls_valid_reg <= 1'b1;
              ls_rdata_reg <= '0;
            end else begin
              if_valid_reg <= 1'b1;
              if_rdata_reg <= '0;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4). Inputs change 1ns after the
// rising edge, outputs are checked on the falling edge.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_valid;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [BW-1:0] ls_be = '0;
  logic          ls_gnt, ls_valid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          err, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .err(err), .busy(busy)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h10; ls_addr = 32'h20;
    @(negedge clk);
    total++; if ({if_gnt, ls_gnt, if_valid, ls_valid, err, mem_req, mem_we, busy} !== 8'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000000", {if_gnt, ls_gnt, if_valid, ls_valid, err, mem_req, mem_we, busy});
    end
    total++; if ({if_rdata, ls_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 0", {if_rdata, ls_rdata});
    end
    total++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
      bad++; $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_wdata, mem_be});
    end
    next_cycle();
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_release_busy: got %b want 0", busy);
    end
    $display("reset: released, busy=%b", busy);
    next_cycle();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    total++; if ({if_gnt, ls_gnt, mem_req} !== 3'b100) begin
      bad++; $display("FAIL fetch_c0_gnt: got %b want 100", {if_gnt, ls_gnt, mem_req});
    end
    next_cycle();
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if ({mem_req, mem_we, mem_be, mem_addr, if_gnt} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b0}) begin
      bad++; $display("FAIL fetch_c1_mem: got req=%b we=%b be=%h addr=%h gnt=%b want 1 0 f 00000100 0",
                      mem_req, mem_we, mem_be, mem_addr, if_gnt);
    end
    next_cycle();
    mem_rdata = 32'h0BADF00D;   // mem_ready still high in IDLE: must be ignored
    @(negedge clk);
    total++; if ({if_valid, ls_valid, err, mem_req} !== 4'b1000 || if_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL fetch_c2_valid: got v=%b lv=%b err=%b req=%b rdata=%h want 1 0 0 0 deadbeef",
                      if_valid, ls_valid, err, mem_req, if_rdata);
    end
    $display("fetch: addr=%h rdata=%h", 32'h100, if_rdata);
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    total++; if ({if_valid, busy} !== 2'b00 || if_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL fetch_idle_ready: got v=%b busy=%b rdata=%h want 0 0 deadbeef", if_valid, busy, if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_store();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h12345678; ls_be = 4'b0011;
    @(negedge clk);
    total++; if ({ls_gnt, if_gnt} !== 2'b10) begin
      bad++; $display("FAIL store_gnt: got %b want 10", {ls_gnt, if_gnt});
    end
    next_cycle();
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'hFFF; ls_wdata = 32'h0; ls_be = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      mem_ready = (k == 4); mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      total++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, ls_valid} !==
                   {1'b1, 1'b1, 4'b0011, 32'h200, 32'h12345678, 1'b0}) begin
        bad++; $display("FAIL store_hold_c%0d: got req=%b we=%b be=%b addr=%h wdata=%h v=%b want 1 1 0011 00000200 12345678 0",
                        k, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ls_valid);
      end
      next_cycle();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    total++; if ({ls_valid, if_valid, err} !== 3'b100 || ls_rdata !== 32'h0) begin
      bad++; $display("FAIL store_c5_valid: got v=%b iv=%b err=%b rdata=%h want 1 0 0 00000000",
                      ls_valid, if_valid, err, ls_rdata);
    end
    $display("store: addr=%h wdata=%h be=0011 rdata=%h", 32'h200, 32'h12345678, ls_rdata);
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ls;
`ifdef MEM_ARB_RR_EN
    exp_ls = 4'b0101;
`else
    exp_ls = 4'b1111;
`endif
    rst = 1'b0; #1; rst = 1'b1;        // put the last-owner flag back to "if"
    if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({ls_gnt, if_gnt} !== (exp_ls[i] ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL b2b_gnt%0d: got ls/if=%b want %b", i, {ls_gnt, if_gnt}, exp_ls[i] ? 2'b10 : 2'b01);
      end
      if (i > 0) begin
        total++; if ({ls_valid, if_valid} !== (exp_ls[i-1] ? 2'b10 : 2'b01) ||
                     (exp_ls[i-1] ? ls_rdata : if_rdata) !== 32'h1000 + 32'(i - 1)) begin
          bad++; $display("FAIL b2b_valid%0d: got ls/if=%b lrd=%h ird=%h want owner=%b data=%h",
                          i - 1, {ls_valid, if_valid}, ls_rdata, if_rdata, exp_ls[i-1], 32'h1000 + 32'(i - 1));
        end
      end
      next_cycle();
      mem_rdata = 32'h1000 + 32'(i);
      @(negedge clk);
      total++; if ({mem_req, ls_gnt, if_gnt} !== 3'b100 || mem_addr !== (exp_ls[i] ? 32'h400 : 32'h300)) begin
        bad++; $display("FAIL b2b_access%0d: got req/gnts=%b addr=%h want 100 %h",
                        i, {mem_req, ls_gnt, if_gnt}, mem_addr, exp_ls[i] ? 32'h400 : 32'h300);
      end
      $display("b2b: access %0d owner=%s addr=%h", i, exp_ls[i] ? "ls" : "if", mem_addr);
      next_cycle();
    end
    if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    total++; if ({ls_valid, if_valid} !== (exp_ls[3] ? 2'b10 : 2'b01) ||
                 (exp_ls[3] ? ls_rdata : if_rdata) !== 32'h1003) begin
      bad++; $display("FAIL b2b_valid3: got ls/if=%b lrd=%h ird=%h want owner=%b data=00001003",
                      {ls_valid, if_valid}, ls_rdata, if_rdata, exp_ls[3]);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h700; mem_ready = 1'b0; mem_rdata = 32'h55555555;
    @(negedge clk);
    total++; if (ls_gnt !== 1'b1) begin
      bad++; $display("FAIL timeout_gnt: got %b want 1", ls_gnt);
    end
    next_cycle();
    ls_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++; if ({mem_req, err, ls_valid} !== 3'b100) begin
        bad++; $display("FAIL timeout_wait_c%0d: got req/err/v=%b want 100", k, {mem_req, err, ls_valid});
      end
      next_cycle();
    end
    @(negedge clk);
    total++; if ({mem_req, ls_valid, err, busy, if_valid} !== 5'b01100 || ls_rdata !== 32'h0) begin
      bad++; $display("FAIL timeout_abort: got req/v/err/busy/iv=%b rdata=%h want 01100 00000000",
                      {mem_req, ls_valid, err, busy, if_valid}, ls_rdata);
    end
    $display("timeout: addr=%h err=%b rdata=%h", 32'h700, err, ls_rdata);
    next_cycle();
    @(negedge clk);
    total++; if ({err, ls_valid} !== 2'b00) begin
      bad++; $display("FAIL timeout_pulse: got err/v=%b want 00", {err, ls_valid});
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    if_req = 1'b1; if_addr = 32'h500; mem_ready = 1'b0;
    @(negedge clk);
    next_cycle();
    if_req = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin
      bad++; $display("FAIL rstmid_before: got req=%b want 1", mem_req);
    end
    #1 rst = 1'b0;
    #1;
    total++; if ({mem_req, busy} !== 2'b00) begin
      bad++; $display("FAIL rstmid_drop: got req/busy=%b want 00", {mem_req, busy});
    end
    next_cycle();
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h77777777;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if ({if_valid, mem_req} !== 2'b00) begin
        bad++; $display("FAIL rstmid_novalid%0d: got v/req=%b want 00", k, {if_valid, mem_req});
      end
      next_cycle();
    end
    $display("rstmid: fetch at 500 aborted by reset");
    if_req = 1'b1; if_addr = 32'h600; mem_ready = 1'b0;
    @(negedge clk);
    total++; if (if_gnt !== 1'b1) begin
      bad++; $display("FAIL rstmid_regnt: got %b want 1", if_gnt);
    end
    next_cycle();
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin
      bad++; $display("FAIL rstmid_reaccess: got req=%b addr=%h want 1 00000600", mem_req, mem_addr);
    end
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    total++; if (if_valid !== 1'b1 || if_rdata !== 32'hA5A5A5A5 || err !== 1'b0) begin
      bad++; $display("FAIL rstmid_revalid: got v=%b rdata=%h err=%b want 1 a5a5a5a5 0", if_valid, if_rdata, err);
    end
    $display("rstmid: refetch addr=%h rdata=%h", 32'h600, if_rdata);
    next_cycle();
  endtask

  // Both grants or both valids high together is always an error.
  always @(negedge clk) begin
    if (rst && ((if_gnt && ls_gnt) || (if_valid && ls_valid))) begin
      bad++;
      total++;
      $display("FAIL exclusive: gnt=%b%b valid=%b%b", if_gnt, ls_gnt, if_valid, ls_valid);
    end
  end

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single-port memory between the instruction-fetch path and the load/store path. It sits between the fetch/LSU requesters and the memory, and replaces ad-hoc sequencing such as the two-phase load trick with an explicit request/grant/valid protocol. It supports variable memory latency and a wait-state watchdog.

## Interface
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 bits)
- TIMEOUT, 255, maximum wait cycles for mem_ready before abort (1..65535)

- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch grant, one-cycle pulse
- if_valid  out  1  fetch complete, one-cycle pulse
- if_rdata  out  DW  fetched word, valid with if_valid
- ls_req  in  1  load/store request; held until ls_gnt
- ls_we  in  1  1 = store
- ls_addr  in  AW  data address
- ls_wdata  in  DW  store data
- ls_be  in  DW/8  store byte enables
- ls_gnt  out  1  data grant, one-cycle pulse
- ls_valid  out  1  data access complete, one-cycle pulse
- ls_rdata  out  DW  load data, valid with ls_valid; 0 for stores
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_be  out  DW/8  memory byte enables (all ones on reads)
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  DW  memory read data, sampled when mem_ready=1
- err  out  1  timeout pulse, coincident with the aborted port's valid
- busy  out  1  1 in FETCH or DATA

## Operation
- FSM states: IDLE, FETCH, DATA.
- IDLE, no request: stay in IDLE.
- IDLE, a request is present: pick a winner and assert the winner's gnt combinationally in the same cycle. Register the winner's addr, we, wdata and be into the access registers. Next state is FETCH or DATA.
- Default arbitration is fixed priority with ls over if (the load/store stalls the pipe).
- FETCH/DATA: mem_req=1. mem_* are driven only from the access registers and are stable for the whole access.
- On mem_ready=1, register mem_rdata into the owner's rdata (ls_rdata=0 for stores), pulse the owner's valid next cycle, and return to IDLE.
- Watchdog: a wait counter clears on grant and increments each FETCH/DATA cycle without mem_ready. When the counter reaches TIMEOUT, abort to IDLE. The next cycle pulses the owner's valid with err=1 and rdata=0.
- mem_ready seen in IDLE is ignored.
- Requests are sampled only in IDLE. req changes during an access have no effect.
- The same requester may be granted again in the IDLE cycle that carries its valid.

## Timing
- Reset (rst=0, async) gives: state IDLE; counter 0; all gnt/valid/err/mem_req/mem_we/busy = 0; rdata, mem_addr, mem_wdata and mem_be = 0.
- rst asserted mid-access drops mem_req immediately. No valid is issued for the aborted access.
- Zero-wait memory: gnt in cycle 0, mem_req in cycle 1 with mem_ready, valid in cycle 2. Peak throughput is one access per 2 cycles.
- N wait states: valid arrives in cycle 2+N.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then valid+err follow one cycle later.
- if_gnt and ls_gnt are never high together. if_valid and ls_valid are never high together.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. When both requests are present in IDLE, grant the port that was not granted last. The last-owner flag resets to "if", so ls wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority, ls always wins ties. If ls requests back-to-back, if may starve.

## Structure
- Shared package header holds state encodings ARB_IDLE/ARB_FETCH/ARB_DATA and owner codes OWN_IF/OWN_LS.
- One sub-module, mem_arb_pick: combinational winner selection from if_req, ls_req and the last-owner flag. The RR/fixed choice lives there under MEM_ARB_RR_EN.
- The FSM, access registers, watchdog and return path live in mem_arbiter.

## Test plan
- Fetch only, addr 0x100, mem_ready in the first cycle: if_gnt at c0, mem_req with mem_addr 0x100 at c1, if_valid with if_rdata = mem_rdata (0xDEADBEEF) at c2.
- Store: addr 0x200, wdata 0x12345678, be 4'b0011, 3 wait states: mem_we=1 and be=0011 held stable for 4 cycles, ls_valid at c5 with ls_rdata=0.
- Simultaneous if_req and ls_req held high for 4 accesses: fixed priority gives grant sequence ls,ls,ls,ls. With MEM_ARB_RR_EN, the sequence is ls,if,ls,if.
- TIMEOUT=4, mem_ready never asserted: mem_req high for 4 cycles, then ls_valid=1, err=1, ls_rdata=0, state IDLE.
- rst pulled low in the middle of a 3-wait-state fetch: mem_req drops in the same cycle, no if_valid follows, and after release a new fetch completes normally.
